// File: rtl/sdram_cmd_decoder.sv
// Device-side SDRAM command decoder: tracks mode register and open rows, and
// expands each RD/WR into one {bank,row,col} beat per cycle for the array model.
module sdram_cmd_decoder #(
  parameter int ROW_W = 12,
  parameter int COL_W = 9,
  parameter int BANKS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cs_n,
  input  logic                      ras_n,
  input  logic                      cas_n,
  input  logic                      we_n,
  input  logic [1:0]                sdc_ba,
  input  logic [ROW_W-1:0]          sdc_ad,
  output logic [2+ROW_W+COL_W-1:0]  mem_adr,
  output logic                      mem_vld,
  output logic                      mem_wr,
  output logic [2:0]                cas_lat,
  output logic [COL_W:0]            burst_len,
  output logic [BANKS-1:0]          bank_open,
  output logic                      cmd_err,
  output logic                      state_dbg
);

  // Beat stream: mem_vld marks exactly one beat per cycle; there is no
  // backpressure, the consumer must accept every beat the cycle it is valid.

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [COL_W:0] PAGE_LEN = {1'b1, {COL_W{1'b0}}};

  state_t                  state, state_n;
  logic [ROW_W-1:0]        row_q [BANKS];
  logic [1:0]              b_bank;
  logic [ROW_W-1:0]        b_row;
  logic [COL_W-1:0]        b_start;
  logic [COL_W:0]          b_cnt;
  logic                    b_ap;

  logic [2:0]              cmd;
  logic                    is_act, is_rd, is_wr, is_rw, is_pre, is_ref, is_mrs, is_bst;
  logic                    any_open, target_open;
  logic                    act_ok, rw_ok;
  logic [2:0]              bl_code;
  logic                    bl_ok;
  logic [COL_W:0]          bl_dec;
  logic                    mrs_load, mrs_err;
  logic                    is_page, done, stop;
  logic [COL_W-1:0]        mask, sum, beat_col;

  logic [2+ROW_W+COL_W-1:0] adr_n;
  logic                    vld_n, wr_n, err_n;
  logic [COL_W:0]          cnt_n;
  logic [BANKS-1:0]        open_n;

  assign cmd       = {ras_n, cas_n, we_n};
  assign is_act    = !cs_n && (cmd == 3'b011);
  assign is_rd     = !cs_n && (cmd == 3'b101);
  assign is_wr     = !cs_n && (cmd == 3'b100);
  assign is_pre    = !cs_n && (cmd == 3'b010);
  assign is_ref    = !cs_n && (cmd == 3'b001);
  assign is_mrs    = !cs_n && (cmd == 3'b000);
  assign is_bst    = !cs_n && (cmd == 3'b110);
  assign is_rw     = is_rd || is_wr;
  assign state_dbg = (state == BURST);

  assign any_open    = |bank_open;
  assign target_open = bank_open[sdc_ba];
  assign act_ok      = is_act && !target_open;
  assign rw_ok       = is_rw && target_open;

  // Mode register: burst codes 0..3 are powers of two, 7 is full page.
  assign bl_code  = sdc_ad[2:0];
  assign bl_ok    = (bl_code[2] == 1'b0) || (bl_code == 3'b111);
  assign bl_dec   = bl_code[2] ? PAGE_LEN : ((COL_W+1)'(1) << bl_code[1:0]);
  assign mrs_load = is_mrs && !any_open && (sdc_ba == 2'b00) && bl_ok;
  assign mrs_err  = is_mrs && (any_open || ((sdc_ba == 2'b00) && !bl_ok));

  // Wrap inside the burst-aligned block; page length leaves mask all ones.
  assign is_page  = burst_len[COL_W];
  assign mask     = burst_len[COL_W-1:0] - COL_W'(1);
  assign sum      = b_start + b_cnt[COL_W-1:0];
  assign beat_col = (b_start & ~mask) | (sum & mask);

  assign done = (state == BURST) && !is_page && (b_cnt == burst_len);
  assign stop = (state == BURST) && !done &&
                (is_bst || (is_pre && (sdc_ad[10] || (sdc_ba == b_bank))));

  always_comb begin
    state_n = state;
    adr_n   = mem_adr;
    vld_n   = 1'b0;
    wr_n    = mem_wr;
    cnt_n   = b_cnt;
    err_n   = mrs_err || (is_act && target_open) || (is_ref && any_open) ||
              (is_rw && !target_open);

    open_n = bank_open;
    if (done && b_ap) open_n[b_bank] = 1'b0;
    if (is_pre) begin
      if (sdc_ad[10]) open_n = '0;
      else            open_n[sdc_ba] = 1'b0;
    end
    if (act_ok) open_n[sdc_ba] = 1'b1;

    if (rw_ok) begin
      state_n = BURST;
      vld_n   = 1'b1;
      adr_n   = {sdc_ba, row_q[sdc_ba], sdc_ad[COL_W-1:0]};
      wr_n    = is_wr;
      cnt_n   = (COL_W+1)'(1);
    end else if (state == BURST) begin
      if (done || stop) begin
        state_n = IDLE;
      end else begin
        vld_n = 1'b1;
        adr_n = {b_bank, b_row, beat_col};
        cnt_n = b_cnt + (COL_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_adr   <= '0;
      mem_vld   <= 1'b0;
      mem_wr    <= 1'b0;
      cas_lat   <= 3'b010;
      burst_len <= (COL_W+1)'(1);
      bank_open <= '0;
      cmd_err   <= 1'b0;
      b_bank    <= '0;
      b_row     <= '0;
      b_start   <= '0;
      b_cnt     <= '0;
      b_ap      <= 1'b0;
      for (int i = 0; i < BANKS; i++) row_q[i] <= '0;
    end else begin
      state     <= state_n;
      mem_adr   <= adr_n;
      mem_vld   <= vld_n;
      mem_wr    <= wr_n;
      bank_open <= open_n;
      cmd_err   <= err_n;
      b_cnt     <= cnt_n;
      if (mrs_load) begin
        cas_lat   <= sdc_ad[6:4];
        burst_len <= bl_dec;
      end
      if (act_ok) row_q[sdc_ba] <= sdc_ad;
      // A new burst overwrites b_ap, which drops a truncated burst's precharge.
      if (rw_ok) begin
        b_bank  <= sdc_ba;
        b_row   <= row_q[sdc_ba];
        b_start <= sdc_ad[COL_W-1:0];
        b_ap    <= sdc_ad[10] && !is_page;
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_decoder.sv
// Bench for sdram_cmd_decoder: directed scenarios plus random commands checked
// against a queue-based behavioural model of banks, mode register and bursts.
module tb_sdram_cmd_decoder;
  localparam int ROW_W = 12;
  localparam int COL_W = 9;
  localparam int BANKS = 4;
  localparam int AW    = 2 + ROW_W + COL_W;
  localparam int VW    = AW + 1 + 1 + 3 + (COL_W + 1) + BANKS + 1 + 1;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000, C_BST = 3'b110;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]        sdc_ba = '0;
  logic [ROW_W-1:0]  sdc_ad = '0;
  logic [AW-1:0]     mem_adr;
  logic              mem_vld, mem_wr, cmd_err, state_dbg;
  logic [2:0]        cas_lat;
  logic [COL_W:0]    burst_len;
  logic [BANKS-1:0]  bank_open;

  sdram_cmd_decoder #(.ROW_W(ROW_W), .COL_W(COL_W), .BANKS(BANKS)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .sdc_ba(sdc_ba), .sdc_ad(sdc_ad), .mem_adr(mem_adr), .mem_vld(mem_vld), .mem_wr(mem_wr),
    .cas_lat(cas_lat), .burst_len(burst_len), .bank_open(bank_open), .cmd_err(cmd_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  bit              m_open [BANKS];
  int              m_row  [BANKS];
  int              m_cas, m_bl, m_bank;
  bit              m_active, m_ap;
  logic [AW-1:0]   exp_q[$];
  logic [AW-1:0]   e_adr;
  bit              e_vld, e_wr, e_err;

  function automatic logic [AW-1:0] mk_adr(int b, int r, int c);
    return (AW'(b) << (ROW_W + COL_W)) | (AW'(r) << COL_W) | AW'(c);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < BANKS; b++) begin
      m_open[b] = 0;
      m_row[b]  = 0;
    end
    m_cas = 2; m_bl = 1; m_bank = 0; m_active = 0; m_ap = 0;
    exp_q.delete();
    e_adr = '0; e_vld = 0; e_wr = 0; e_err = 0;
  endtask

  task automatic model_cmd(input bit cs, input logic [2:0] c, input int ba, input int ad);
    bit any_open, done, stop, rw_ok, ap_fire, code_ok, a10;
    bit is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, is_bst;
    int code, old_bank, base, start;
    any_open = 0;
    for (int b = 0; b < BANKS; b++) any_open |= m_open[b];
    is_act = !cs && c == C_ACT;  is_rd  = !cs && c == C_RD;   is_wr  = !cs && c == C_WR;
    is_pre = !cs && c == C_PRE;  is_ref = !cs && c == C_REF;  is_mrs = !cs && c == C_MRS;
    is_bst = !cs && c == C_BST;
    a10      = ((ad >> 10) & 1) != 0;
    done     = m_active && exp_q.size() == 0;
    ap_fire  = done && m_ap;
    old_bank = m_bank;
    stop     = m_active && !done && (is_bst || (is_pre && (a10 || ba == m_bank)));
    e_err    = 0;

    if (is_mrs) begin
      code    = ad & 7;
      code_ok = (code <= 3) || (code == 7);
      if (any_open || (ba == 0 && !code_ok)) e_err = 1;
      else if (ba == 0) begin
        m_cas = (ad >> 4) & 7;
        m_bl  = (code == 7) ? (1 << COL_W) : (1 << code);
      end
    end
    if (is_act) begin
      if (m_open[ba]) e_err = 1;
      else begin
        m_open[ba] = 1;
        m_row[ba]  = ad;
      end
    end
    if (is_ref && any_open) e_err = 1;
    rw_ok = (is_rd || is_wr) && m_open[ba];
    if ((is_rd || is_wr) && !m_open[ba]) e_err = 1;

    e_vld = 0;
    if (rw_ok) begin
      exp_q.delete();
      start = ad % (1 << COL_W);
      base  = start - (start % m_bl);
      for (int i = 0; i < m_bl; i++)
        exp_q.push_back(mk_adr(ba, m_row[ba], base + (start + i) % m_bl));
      m_active = 1;
      m_bank   = ba;
      m_ap     = a10 && (m_bl != (1 << COL_W));
      e_wr     = is_wr;
    end else if (m_active && (done || stop)) begin
      m_active = 0;
      exp_q.delete();
    end
    if (m_active && exp_q.size() > 0) begin
      e_adr = exp_q.pop_front();
      e_vld = 1;
    end

    if (is_pre) begin
      if (a10) for (int b = 0; b < BANKS; b++) m_open[b] = 0;
      else m_open[ba] = 0;
    end
    if (ap_fire) m_open[old_bank] = 0;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [BANKS-1:0] o;
    for (int b = 0; b < BANKS; b++) o[b] = m_open[b];
    return {e_adr, e_vld, e_wr, 3'(m_cas), (COL_W+1)'(m_bl), o, e_err, m_active};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {mem_adr, mem_vld, mem_wr, cas_lat, burst_len, bank_open, cmd_err, state_dbg};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit cs, input logic [2:0] c, input int ba, input int ad);
    cs_n = cs;
    {ras_n, cas_n, we_n} = c;
    sdc_ba = 2'(ba);
    sdc_ad = ROW_W'(ad);
    model_cmd(cs, c, ba, ad);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (mem_adr !== '0 || mem_vld !== 1'b0 || mem_wr !== 1'b0 || cas_lat !== 3'b010 ||
        burst_len !== 10'd1 || bank_open !== 4'b0000 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got=%h exp_cas=2 bl=1 rest=0", obs_vec());
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, C_MRS, 0, 'h032);
    total++;
    if (cas_lat !== 3'd3 || burst_len !== 10'd4 || cmd_err !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL mrs_bl4 got cas=%0d bl=%0d err=%b exp cas=3 bl=4 err=0", cas_lat, burst_len, cmd_err);
    end
  endtask

  task automatic test_read_wrap();
    logic [COL_W-1:0] cols [4] = '{9'h0FE, 9'h0FF, 9'h0FC, 9'h0FD};
    step(0, C_ACT, 1, 'h0A5);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL act_bank1 got=%h exp=%h", obs_vec(), exp_vec());
    end
    step(0, C_RD, 1, 'h0FE);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_vld !== 1'b1 || mem_wr !== 1'b0 || mem_adr !== {2'd1, 12'h0A5, cols[i]} ||
          obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL rd_wrap beat%0d got adr=%h vld=%b wr=%b exp adr=%h", i, mem_adr, mem_vld,
                 mem_wr, {2'd1, 12'h0A5, cols[i]});
      end
      step(1, C_NOP, 0, 0);
    end
    total++;
    if (mem_vld !== 1'b0 || bank_open !== 4'b0010 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL rd_wrap_end got vld=%b open=%b exp vld=0 open=0010", mem_vld, bank_open);
    end
  endtask

  task automatic test_write_ap();
    logic [COL_W-1:0] cols [8] = '{9'h003, 9'h004, 9'h005, 9'h006, 9'h007, 9'h000, 9'h001, 9'h002};
    step(0, C_PRE, 0, 'h400);
    step(0, C_MRS, 0, 'h033);
    total++;
    if (burst_len !== 10'd8 || cmd_err !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL mrs_bl8 got bl=%0d err=%b exp bl=8 err=0", burst_len, cmd_err);
    end
    step(0, C_ACT, 2, 'h3C3);
    step(0, C_WR, 2, 'h403);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem_vld !== 1'b1 || mem_wr !== 1'b1 || mem_adr !== {2'd2, 12'h3C3, cols[i]} ||
          bank_open[2] !== 1'b1 || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL wr_ap beat%0d got adr=%h vld=%b wr=%b open=%b exp adr=%h", i, mem_adr,
                 mem_vld, mem_wr, bank_open, {2'd2, 12'h3C3, cols[i]});
      end
      step(1, C_NOP, 0, 0);
    end
    total++;
    if (mem_vld !== 1'b0 || bank_open[2] !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL wr_ap_close got vld=%b open=%b exp vld=0 open[2]=0", mem_vld, bank_open);
    end
  endtask

  task automatic test_page_pre();
    logic [COL_W-1:0] cols [3] = '{9'h1FE, 9'h1FF, 9'h000};
    step(0, C_PRE, 0, 'h400);
    step(0, C_MRS, 0, 'h037);
    total++;
    if (burst_len !== 10'd512 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL mrs_page got bl=%0d exp bl=512", burst_len);
    end
    step(0, C_ACT, 0, 'h111);
    step(0, C_RD, 0, 'h1FE);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem_vld !== 1'b1 || mem_adr !== {2'd0, 12'h111, cols[i]} || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL page beat%0d got adr=%h vld=%b exp adr=%h", i, mem_adr, mem_vld,
                 {2'd0, 12'h111, cols[i]});
      end
      if (i < 2) step(1, C_NOP, 0, 0);
      else       step(0, C_PRE, 0, 'h000);
    end
    total++;
    if (mem_vld !== 1'b0 || bank_open[0] !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL page_pre_stop got vld=%b open=%b exp vld=0 open[0]=0", mem_vld, bank_open);
    end
  endtask

  task automatic test_errors();
    int pulses = 0;
    logic [2:0] cmds [10] = '{C_RD, C_NOP, C_ACT, C_ACT, C_NOP, C_REF, C_NOP, C_PRE, C_MRS, C_NOP};
    int         bas  [10] = '{3, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int         ads  [10] = '{'h005, 0, 'h222, 'h333, 0, 0, 0, 'h400, 'h034, 0};
    bit         errs [10] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      step(cmds[i] == C_NOP, cmds[i], bas[i], ads[i]);
      pulses += int'(cmd_err);
      total++;
      if (cmd_err !== errs[i] || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL err_step%0d got err=%b vec=%h exp err=%b vec=%h", i, cmd_err, obs_vec(),
                 errs[i], exp_vec());
      end
    end
    total++;
    if (pulses !== 4 || burst_len !== 10'd512 || cas_lat !== 3'd3 || mem_vld !== 1'b0) begin
      bad++;
      $display("FAIL err_summary got pulses=%0d bl=%0d cas=%0d exp pulses=4 bl=512 cas=3",
               pulses, burst_len, cas_lat);
    end
  endtask

  task automatic test_back_to_back();
    step(0, C_MRS, 0, 'h032);
    step(0, C_ACT, 3, 'h0AA);
    step(0, C_RD, 3, 'h005);
    total++;
    if (mem_adr !== {2'd3, 12'h0AA, 9'h005} || mem_vld !== 1'b1 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL b2b_rd0 got adr=%h vld=%b exp adr=%h", mem_adr, mem_vld, {2'd3, 12'h0AA, 9'h005});
    end
    step(1, C_NOP, 0, 0);
    step(0, C_WR, 3, 'h010);
    total++;
    if (mem_adr !== {2'd3, 12'h0AA, 9'h010} || mem_vld !== 1'b1 || mem_wr !== 1'b1 ||
        obs_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL b2b_wr0 got adr=%h vld=%b wr=%b exp adr=%h wr=1", mem_adr, mem_vld, mem_wr,
               {2'd3, 12'h0AA, 9'h010});
    end
    step(1, C_NOP, 0, 0);
    total++;
    if (mem_adr !== {2'd3, 12'h0AA, 9'h011} || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL b2b_wr1 got adr=%h exp adr=%h", mem_adr, {2'd3, 12'h0AA, 9'h011});
    end
    idle_pins();
    reset_n = 1'b0;
    #1;
    total++;
    if (mem_adr !== '0 || mem_vld !== 1'b0 || mem_wr !== 1'b0 || cas_lat !== 3'b010 ||
        burst_len !== 10'd1 || bank_open !== 4'b0000 || cmd_err !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h exp cas=2 bl=1 rest=0", obs_vec());
    end
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL after_reset got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int r, ba, ad, shown;
    bit cs;
    logic [2:0] c;
    shown = 0;
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      ba = $urandom_range(0, 3);
      ad = $urandom_range(0, 4095);
      cs = 0;
      if (r < 28)      c = C_NOP;
      else if (r < 43) c = C_ACT;
      else if (r < 53) c = C_RD;
      else if (r < 63) c = C_WR;
      else if (r < 73) begin
        c  = C_PRE;
        ad = ($urandom_range(0, 2) == 0) ? 'h400 : (ad & 'hBFF);
      end
      else if (r < 77) c = C_REF;
      else if (r < 82) c = C_BST;
      else if (r < 92) begin
        c  = C_MRS;
        ba = ($urandom_range(0, 4) == 0) ? 1 : 0;
        ad = ($urandom_range(0, 7) << 4) | $urandom_range(0, 7);
      end
      else begin
        cs = 1;
        c  = 3'($urandom_range(0, 7));
      end
      step(cs, c, ba, ad);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        if (shown < 10) $display("FAIL random cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
        shown++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_read_wrap();
    test_write_ap();
    test_page_pre();
    test_errors();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
